// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: signal bundle between the fetch/data requesters, mem_arbiter and a single-port memory
//   fetch port : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   data port  : d_req, d_we, d_size, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata, d_err
//   memory port: m_addr, m_wdata, m_rw -> m_rdata (combinational read of m_addr)
//   slave modport is the arbiter's view, master modport is the environment's view
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_rw;
   logic [31:0] m_rdata;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err, m_addr, m_wdata, m_rw
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err, m_addr, m_wdata, m_rw
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one single-port word memory
//   clock   : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_arbiter_if.slave (fetch, data and memory signals)
//   ARB_RR_EN: when defined, contention alternates between ports; otherwise data always wins
module mem_arbiter (
   input logic          clock,
   input logic          reset_n,
   mem_arbiter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;
   state_t      state;
   logic        owner_d;
   logic [3:0]  be, be_n;
   logic [31:0] wd, wd_n, merged;
   logic [31:0] m_addr, m_wdata, i_rdata, d_rdata;
   logic        m_rw, i_rvalid, d_rvalid, d_err;
   logic        idle, bad, d_win, i_win;
   assign idle = state == IDLE;
   assign bad  = bus.d_size == 2'b11 || (bus.d_size == 2'b01 && bus.d_addr[0]) ||
                 (bus.d_size == 2'b10 && bus.d_addr[1:0] != 2'b00);
`ifdef ARB_RR_EN
   logic last_d;
   assign d_win = idle && bus.d_req && (!bus.i_req || !last_d);
`else
   assign d_win = idle && bus.d_req;
`endif
   assign i_win = idle && bus.i_req && !d_win;
   // sub-word store data is replicated across lanes so the byte enables alone select it
   assign be_n = bus.d_size[0] ? (bus.d_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << bus.d_addr[1:0];
   assign wd_n = bus.d_size[0] ? {2{bus.d_wdata[15:0]}} : {4{bus.d_wdata[7:0]}};
   always_comb begin
      merged = bus.m_rdata;
      for (int k = 0; k < 4; k++)
         if (be[k]) merged[8*k +: 8] = wd[8*k +: 8];
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state    <= IDLE;
         owner_d  <= 1'b0;
         be       <= '0;
         wd       <= '0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_rw     <= 1'b0;
         i_rvalid <= 1'b0;
         i_rdata  <= '0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
         d_err    <= 1'b0;
`ifdef ARB_RR_EN
         last_d   <= 1'b0;
`endif
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         d_err    <= 1'b0;
`ifdef ARB_RR_EN
         if (d_win || i_win) last_d <= d_win;
`endif
         case (state)
            IDLE:
               if (d_win) begin
                  if (bad) begin
                     // rejected without touching memory; the error response follows next cycle
                     d_rvalid <= 1'b1;
                     d_err    <= 1'b1;
                     d_rdata  <= '0;
                  end else begin
                     owner_d <= 1'b1;
                     m_addr  <= {bus.d_addr[31:2], 2'b00};
                     if (!bus.d_we) state <= RD;
                     else if (bus.d_size == 2'b10) begin
                        state   <= WR;
                        m_rw    <= 1'b1;
                        m_wdata <= bus.d_wdata;
                     end else begin
                        state <= RMW_RD;
                        be    <= be_n;
                        wd    <= wd_n;
                     end
                  end
               end else if (i_win) begin
                  owner_d <= 1'b0;
                  m_addr  <= {bus.i_addr[31:2], 2'b00};
                  state   <= RD;
               end
            RD: begin
               state <= IDLE;
               if (owner_d) begin
                  d_rvalid <= 1'b1;
                  d_rdata  <= bus.m_rdata;
               end else begin
                  i_rvalid <= 1'b1;
                  i_rdata  <= bus.m_rdata;
               end
            end
            RMW_RD: begin
               state   <= RMW_WR;
               m_rw    <= 1'b1;
               m_wdata <= merged;
            end
            default: begin
               state    <= IDLE;
               m_rw     <= 1'b0;
               m_wdata  <= '0;
               d_rvalid <= 1'b1;
               d_rdata  <= '0;
            end
         endcase
      end
   assign bus.i_gnt    = i_win;
   assign bus.d_gnt    = d_win;
   assign bus.i_rvalid = i_rvalid;
   assign bus.i_rdata  = i_rdata;
   assign bus.d_rvalid = d_rvalid;
   assign bus.d_rdata  = d_rdata;
   assign bus.d_err    = d_err;
   assign bus.m_addr   = m_addr;
   assign bus.m_wdata  = m_wdata;
   assign bus.m_rw     = m_rw;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a word-array reference memory
module tb_mem_arbiter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;
   mem_arbiter_if bus();
   mem_arbiter dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        poke_en = 1'b0;
   logic [5:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   int checks = 0, errors = 0;
   assign bus.m_rdata = mem[bus.m_addr[7:2]];
   always @(posedge clock)
      if (bus.m_rw) mem[bus.m_addr[7:2]] <= bus.m_wdata;
      else if (poke_en) mem[poke_idx] <= poke_val;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic poke(int idx, logic [31:0] val);
      ref_mem[idx] = val;
      poke_idx = 6'(idx);
      poke_val = val;
      poke_en = 1'b1;
      @(posedge clock);
      #1 poke_en = 1'b0;
   endtask
   task automatic do_fetch(logic [31:0] addr);
      int lat;
      logic [31:0] data;
      lat = 0;
      data = 'x;
      @(negedge clock);
      bus.i_req = 1'b1;
      bus.i_addr = addr;
      #1 check("i_gnt", 32'(bus.i_gnt), 32'd1);
      @(negedge clock);
      bus.i_req = 1'b0;
      check("i_m_addr", bus.m_addr, addr & 32'hFFFF_FFFC);
      for (int k = 2; k <= 5 && lat == 0; k++) begin
         @(negedge clock);
         if (bus.i_rvalid) begin
            lat = k;
            data = bus.i_rdata;
            check("rv_excl", 32'(bus.d_rvalid), 32'd0);
         end
      end
      check("i_lat", lat, 2);
      check("i_rdata", data, ref_mem[addr[7:2]]);
   endtask
   task automatic do_data(logic we, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
      int lat, rw_n, rw_k, exp_lat, sh;
      logic [31:0] data, err, wr, mask, nw;
      logic bad;
      bad = size == 2'd3 || (addr & ((32'd1 << size) - 1)) != 0;
      sh = 8 * int'(addr[1:0]);
      mask = size == 2'd2 ? 32'hFFFF_FFFF : ((32'd1 << (8 << size)) - 1) << sh;
      nw = (ref_mem[addr[7:2]] & ~mask) | ((wdata << sh) & mask);
      exp_lat = bad ? 1 : (we && size != 2'd2) ? 3 : 2;
      lat = 0; rw_n = 0; rw_k = 0;
      data = 'x; err = 'x; wr = 'x;
      @(negedge clock);
      bus.d_req = 1'b1;
      bus.d_we = we;
      bus.d_size = size;
      bus.d_addr = addr;
      bus.d_wdata = wdata;
      #1 check("d_gnt", 32'(bus.d_gnt), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         bus.d_req = 1'b0;
         if (bus.m_rw) begin
            rw_n++;
            rw_k = k;
            wr = bus.m_wdata;
         end
         if (bus.d_rvalid && lat == 0) begin
            lat = k;
            data = bus.d_rdata;
            err = 32'(bus.d_err);
            check("rv_excl", 32'(bus.i_rvalid), 32'd0);
         end
      end
      check("d_lat", lat, exp_lat);
      check("d_err", err, 32'(bad));
      if (bad || !we) begin
         check("d_no_write", rw_n, 0);
         check("d_rdata", data, bad ? 32'd0 : ref_mem[addr[7:2]]);
      end else begin
         check("d_write_cnt", rw_n, 1);
         check("d_write_cyc", rw_k, size == 2'd2 ? 1 : 2);
         check("d_m_wdata", wr, nw);
         ref_mem[addr[7:2]] = nw;
      end
   endtask
   initial begin
      int n, last_d, busy, win_d, bad_words;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;
      for (int i = 0; i < 64; i++) poke(i, $urandom);
      #1;
      check("rst_m_rw", 32'(bus.m_rw), 32'd0);
      check("rst_m_addr", bus.m_addr, 32'd0);
      check("rst_m_wdata", bus.m_wdata, 32'd0);
      check("rst_rvalid", {30'd0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
      check("rst_err", 32'(bus.d_err), 32'd0);
      check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      poke(1, 32'hDEADBEEF);
      do_fetch(32'h0100_0004);
      poke(4, 32'h1122_3344);
      do_data(1'b1, 2'd0, 32'h0100_0012, 32'h0000_00AB);
      check("byte_merge", mem[4], 32'h11AB_3344);
      do_data(1'b0, 2'd2, 32'h0100_0002, 32'h0);
      do_fetch(32'h0100_0007);
      for (int t = 0; t < 80; t++) begin
         if ($urandom_range(0, 2) == 0) do_fetch(32'h0100_0000 | $urandom_range(0, 255));
         else do_data(1'($urandom), 2'($urandom), 32'h0100_0000 | $urandom_range(0, 255), $urandom);
      end
      bad_words = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad_words++;
      check("mem_image", bad_words, 0);
      poke(2, 32'h55AA_55AA);
      @(negedge clock);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd2;
      bus.d_addr = 32'h0100_0008; bus.d_wdata = 32'hCAFE_F00D;
      #1 check("wr_gnt", 32'(bus.d_gnt), 32'd1);
      @(posedge clock);
      #1 check("wr_rw", 32'(bus.m_rw), 32'd1);
      #1 reset_n = 1'b0;
      bus.d_req = 1'b0;
      #1 check("rst_drop_rw", 32'(bus.m_rw), 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (bus.d_rvalid) n++;
      end
      check("rst_no_rvalid", n, 0);
      check("rst_mem_kept", mem[2], 32'h55AA_55AA);
      do_fetch(32'h0100_0008);
      // both ports hold a load request; the last grant above went to fetch
      @(negedge clock);
      bus.i_req = 1'b1; bus.i_addr = 32'h0100_0020;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h0100_0030;
      last_d = 0;
      busy = 0;
      for (int c = 0; c < 6; c++) begin
         win_d = 0;
         if (busy == 0) begin
`ifdef ARB_RR_EN
            win_d = last_d == 0;
`else
            win_d = 1;
`endif
            last_d = win_d;
         end
         #1;
         check("ct_d_gnt", 32'(bus.d_gnt), busy == 0 && win_d == 1);
         check("ct_i_gnt", 32'(bus.i_gnt), busy == 0 && win_d == 0);
         busy = busy == 0 ? 1 : 0;
         @(negedge clock);
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      repeat (4) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
